gate_truth_table_checker: RTL and testbench

//   Sequential stimulus/response wrapper around the six-output mux-based gate unit (and/or/nand/nor/xor/xnor).

---
 rtl/gate_truth_table_checker.sv | 150 +++++++++++++++
 tb/tb_gate_truth_table_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_table_checker
//
// Runs a single stimulus/response sweep over a six-output gate unit
// (and/or/nand/nor/xor/xnor). On an accepted start it drives {a,b} through
// 00, 01, 10, 11. Each vector is held for SETTLE_CYCLES cycles and then
// sampled for one cycle. Every sample is compared against the ideal truth
// table. At the end it reports pass/fail, a per-gate error mask and a
// per-vector failure map.
//
// Parameters
//   SETTLE_CYCLES  cycles a/b are held before sampling (legal range 1..15)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   sweep request, only looked at in IDLE
//   a_out     out  stimulus a (registered, = idx[1])
//   b_out     out  stimulus b (registered, = idx[0])
//   gate_in   in   {xnor,xor,nor,nand,or,and} from the gate unit
//   busy      out  high from the cycle after start is accepted until DONE is left
//   done      out  one-cycle pulse at the end of a sweep
//   pass      out  1 = last sweep saw no mismatch
//   err_mask  out  sticky per-gate mismatch flags (gate_in bit order)
//   fail_vec  out  sticky per-vector mismatch flags, bit k = vector {a,b}=k
//
// State table
//   IDLE   | waiting for start, a/b parked at 00
//   SETTLE | holding a/b = idx while the gate unit settles
//   SAMPLE | comparing gate_in against the truth table for idx
//   DONE   | publishing pass and pulsing done
// -----------------------------------------------------------------------------
module gate_truth_table_checker #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic [5:0] gate_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_mask,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] cnt;

    logic       exp_a;
    logic       exp_b;
    logic [5:0] exp_vec;
    logic [5:0] mismatch;

    // A bit counts as a match only when it positively equals the expected
    // value. An unknown compare result falls into the else branch, so
    // X/Z on gate_in is reported as a mismatch.
    always_comb begin
        exp_a   = idx[1];
        exp_b   = idx[0];
        exp_vec = {~(exp_a ^ exp_b), exp_a ^ exp_b, ~(exp_a | exp_b),
                   ~(exp_a & exp_b), exp_a | exp_b, exp_a & exp_b};
        mismatch = 6'b111111;
        for (int i = 0; i < 6; i++) begin
            if (gate_in[i] == exp_vec[i]) begin
                mismatch[i] = 1'b0;
            end else begin
                mismatch[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            cnt      <= 4'd0;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_mask <= 6'd0;
            fail_vec <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= 2'd0;
                        cnt      <= CNT_LOAD;
                        a_out    <= 1'b0;
                        b_out    <= 1'b0;
                        err_mask <= 6'd0;
                        fail_vec <= 4'd0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_mask      <= err_mask | mismatch;
                    fail_vec[idx] <= fail_vec[idx] | (|mismatch);
                    if (idx != 2'd3) begin
                        idx            <= idx + 2'd1;
                        {a_out, b_out} <= idx + 2'd1;
                        cnt            <= CNT_LOAD;
                        state          <= SETTLE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // err_mask already holds the idx=3 sample taken on the
                    // edge that entered DONE.
                    done  <= 1'b1;
                    pass  <= (err_mask == 6'd0);
                    busy  <= 1'b0;
                    idx   <= 2'd0;
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

    typedef struct packed {
        logic       pass;
        logic [5:0] mask;
        logic [3:0] fv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start2;
    logic       a1, b1, a2, b2;
    logic [5:0] gate_in1, gate_in2;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [5:0] err_mask1, err_mask2;
    logic [3:0] fail_vec1, fail_vec2;

    logic [1:0] d1_1 = 2'b00, d2_1 = 2'b00, d1_2 = 2'b00, d2_2 = 2'b00;
    int         mode;
    logic       sel;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
        .gate_in(gate_in1), .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(err_mask1), .fail_vec(fail_vec1)
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
        .gate_in(gate_in2), .busy(busy2), .done(done2), .pass(pass2),
        .err_mask(err_mask2), .fail_vec(fail_vec2)
    );

    function automatic logic [5:0] ideal(input logic [1:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    // Gate unit models: 0 ideal, 1 xor stuck-0, 2 and stuck-1, 3 two-cycle delay
    always @(posedge clk) begin
        d1_1 <= {a1, b1};
        d2_1 <= d1_1;
        d1_2 <= {a2, b2};
        d2_2 <= d1_2;
    end

    always_comb begin
        gate_in1 = ideal({a1, b1});
        case (mode)
            1:       gate_in1 = ideal({a1, b1}) & 6'b101111;
            2:       gate_in1 = ideal({a1, b1}) | 6'b000001;
            3:       gate_in1 = ideal(d2_1);
            default: gate_in1 = ideal({a1, b1});
        endcase
        gate_in2 = ideal(d2_2);
    end

    // Expected sweep result for dut1 under a given gate model. The delayed
    // model shows vector k the response to vector k-1 (vector 0 sees the
    // idle 00 response, since a/b rest at 00 before a sweep).
    function automatic exp_t model(input int m);
        exp_t       e;
        logic [5:0] seen, d;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            case (m)
                1:       seen = ideal(2'(k)) & 6'b101111;
                2:       seen = ideal(2'(k)) | 6'b000001;
                3:       seen = ideal(2'((k == 0) ? 0 : k - 1));
                default: seen = ideal(2'(k));
            endcase
            d = seen ^ ideal(2'(k));
            e.mask  = e.mask | d;
            e.fv[k] = |d;
        end
        e.pass = (e.mask == 6'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start2 = v;
        else     start1 = v;
    endtask

    function automatic logic m_done();
        return sel ? done2 : done1;
    endfunction

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pass"}, sel ? pass2 : pass1, e.pass);
            chk({tag, "_err_mask"}, sel ? err_mask2 : err_mask1, e.mask);
            chk({tag, "_fail_vec"}, sel ? fail_vec2 : fail_vec1, e.fv);
        end
    endtask

    // One sweep: start pulse, optional a/b tracking, optional mid-sweep
    // re-pulse, then latency and result checks. n counts edges after the
    // edge that accepted start.
    task automatic sweep(input string tag, input logic which, input int settle,
                         input exp_t e, input bit check_ab, input int pulse_at);
        int         n;
        logic [1:0] exp_ab;
        sel = which;
        sb.push_back(e);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        n = 0;
        chk({tag, "_busy"}, which ? busy2 : busy1, 1'b1);
        while (!m_done() && n < 60) begin
            if (check_ab) begin
                exp_ab = 2'((n / (settle + 1) > 3) ? 3 : n / (settle + 1));
                chk($sformatf("%s_ab_e%0d", tag, n), {a1, b1}, exp_ab);
            end
            if (n == pulse_at) set_start(1'b1);
            @(negedge clk);
            set_start(1'b0);
            n++;
        end
        chk({tag, "_latency"}, n, 4 * (settle + 1) + 1);
        check_result(tag);
        chk({tag, "_ab_idle"}, which ? {a2, b2} : {a1, b1}, 2'b00);
        chk({tag, "_busy_end"}, which ? busy2 : busy1, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        exp_t ok;
        ok     = '0;
        ok.pass = 1'b1;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        sel    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_pass", pass1, 1'b0);
        chk("rst_err_mask", err_mask1, 6'd0);
        chk("rst_fail_vec", fail_vec1, 4'd0);
        chk("rst_ab", {a1, b1}, 2'b00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // ideal gates with a/b sequence tracking
        mode = 0;
        sweep("ideal", 1'b0, 1, model(0), 1'b1, -1);

        // xor stuck at 0
        mode = 1;
        sweep("xor_sa0", 1'b0, 1, model(1), 1'b0, -1);
        chk("xor_sa0_mask_const", err_mask1, 6'b010000);
        chk("xor_sa0_fv_const", fail_vec1, 4'b0110);

        // and stuck at 1
        mode = 2;
        sweep("and_sa1", 1'b0, 1, model(2), 1'b0, -1);
        chk("and_sa1_fv_const", fail_vec1, 4'b0111);

        // slow gate unit: too short a settle on dut1, enough on dut2
        mode = 3;
        sweep("delay_s1", 1'b0, 1, model(3), 1'b0, -1);
        chk("delay_s1_pass_const", pass1, 1'b0);
        mode = 0;
        sweep("delay_s2", 1'b1, 2, ok, 1'b0, -1);

        // reset at idx=2 after a mismatch has already been recorded
        mode = 1;
        sel  = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_ab", {a1, b1}, 2'b10);
        chk("pre_rst_err_mask", err_mask1, 6'b010000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy1, 1'b0);
        chk("mid_rst_ab", {a1, b1}, 2'b00);
        chk("mid_rst_err_mask", err_mask1, 6'd0);
        chk("mid_rst_fail_vec", fail_vec1, 4'd0);
        chk("mid_rst_pass", pass1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        repeat (3) @(negedge clk);
        sweep("post_rst", 1'b0, 1, model(0), 1'b1, -1);

        // start re-pulsed mid-sweep is ignored
        mode = 1;
        sweep("repulse", 1'b0, 1, model(1), 1'b0, 4);

        // start held high: back-to-back sweeps 10 cycles apart
        mode = 0;
        sel  = 1'b0;
        sb.push_back(model(0));
        sb.push_back(model(0));
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        n = 0;
        while (!done1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("held_first_done", n, 9);
        check_result("held1");
        @(negedge clk);
        n++;
        while (!done1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        start1 = 1'b0;
        chk("held_second_done", n, 19);
        check_result("held2");
        repeat (3) @(negedge clk);
        chk("held_no_third", busy1, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
